// File: rtl/if_id_queue_pkg.sv
// Shared bundle layout for the fetch-to-decode instruction queue.
// Bundle packing is {inst, pc, ex_fields}; ex_valid is the top bit of ex_fields.
package if_id_queue_pkg;

  localparam int EX_FIELDS_LEN = 16;
  localparam int IF2ID_LEN     = 64 + EX_FIELDS_LEN;
  localparam int EX_VALID_BIT  = EX_FIELDS_LEN - 1;

  typedef struct packed {
    logic [31:0]              inst;
    logic [31:0]              pc;
    logic [EX_FIELDS_LEN-1:0] ex_fields;
  } if2id_t;

  function automatic logic [IF2ID_LEN-1:0] pack_bundle(
    input logic [31:0]              inst,
    input logic [31:0]              pc,
    input logic [EX_FIELDS_LEN-1:0] ex_fields
  );
    if2id_t b;
    b.inst      = inst;
    b.pc        = pc;
    b.ex_fields = ex_fields;
    return b;
  endfunction

endpackage

// File: rtl/if_id_queue_fifo_ptr_ctrl.sv
// Read/write pointers, occupancy count and full/empty flags for a circular buffer.
// A clear resets everything and overrides any push or pop in the same cycle.
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({push, pop})
        2'b10: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = count_q + CNT_W'(1);
        end
        2'b01: begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
        end
        2'b11: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr = rd_ptr_q;
  assign wr_ptr = wr_ptr_q;
  assign count  = count_q;
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: in-order buffer of fetch bundles that
// absorbs decode backpressure and drops all contents on a pipeline redirect.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = IF2ID_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       br_taken,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_zip,
  output logic                       in_allowin,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_zip,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             clear;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign clear = flush | br_taken;
  // in_allowin depends only on registered count, so a full queue refuses input
  // even when decode drains the head in the same cycle.
  assign in_allowin = ~full;
  assign out_valid  = ~empty & ~clear;
  assign push       = in_valid & in_allowin & ~clear;
  assign pop        = out_valid & out_ready;

  fifo_ptr_ctrl #(
    .DEPTH(DEPTH)
  ) u_ptr_ctrl (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .rd_ptr(rd_ptr),
    .wr_ptr(wr_ptr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Storage needs no reset: entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= in_zip;
    end
  end

  assign out_zip = mem_q[rd_ptr];

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: the driver predicts acceptance and queues
// expected bundles; a negedge monitor pops and compares every consumed bundle.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = IF2ID_LEN;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         br_taken;
  logic         in_valid;
  logic [W-1:0] in_zip;
  logic         in_allowin;
  logic         out_valid;
  logic [W-1:0] out_zip;
  logic         out_ready;
  logic [2:0]   count;

  logic [W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .br_taken  (br_taken),
    .in_valid  (in_valid),
    .in_zip    (in_zip),
    .in_allowin(in_allowin),
    .out_valid (out_valid),
    .out_zip   (out_zip),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [127:0] act, logic [127:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endfunction

  function automatic logic [W-1:0] mk(input logic [31:0] pc);
    return pack_bundle(pc ^ 32'h0280_0000, pc, 16'h0000);
  endfunction

  // Monitor: every bundle decode consumes must be the oldest expected one.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_when_empty", {127'd0, out_valid}, 128'd0);
      end else begin
        $display("pop pc=%08h zip=%0h", out_zip[47:16], out_zip);
        check("pop_zip", out_zip, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; drives one cycle, checks flags, advances the model.
  task automatic step(input logic v, input logic [W-1:0] z, input logic rdy,
                      input logic fl, input logic br);
    bit clr, acc;
    int sz;
    in_valid  = v;
    in_zip    = z;
    out_ready = rdy;
    flush     = fl;
    br_taken  = br;
    clr = fl | br;
    sz  = exp_q.size();
    acc = v && (sz != DEPTH) && !clr;
    #1;
    check("in_allowin", {127'd0, in_allowin}, {127'd0, sz != DEPTH});
    check("out_valid", {127'd0, out_valid}, {127'd0, (sz != 0) && !clr});
    check("count", {125'd0, count}, 128'(sz));
    if (sz != 0 && !clr) check("head_zip", out_zip, exp_q[0]);
    @(posedge clk);
    if (clr) exp_q.delete();
    else if (acc) exp_q.push_back(z);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; br_taken = 1'b0;
    in_valid = 1'b0; in_zip = '0; out_ready = 1'b0;
    #3;
    check("rst_allowin", {127'd0, in_allowin}, 128'd1);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_count", {125'd0, count}, 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Three pushes with decode stalled; head must be the first pc.
    for (int i = 0; i < 3; i++) step(1, mk(32'h1c00_0000 + 32'(4 * i)), 0, 0, 0);
    step(0, '0, 0, 0, 0);
    check("head_pc_first", {96'd0, out_zip[47:16]}, 128'h1c00_0000);

    // Fill, offer a 5th bundle while full (with and without a pop), drain.
    step(1, mk(32'h1c00_000c), 0, 0, 0);
    check("full_count", {125'd0, count}, 128'd4);
    step(1, mk(32'h1c00_0010), 0, 0, 0);
    step(1, mk(32'h1c00_0014), 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    check("drained_count", {125'd0, count}, 128'd0);

    // Streaming: one in, one out per cycle across pointer wrap.
    step(1, mk(32'h1c00_0100), 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(1, mk(32'h1c00_0100 + 32'(4 * i)), 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);

    // Taken branch at count 3 with a bundle on the input: everything dropped.
    for (int i = 0; i < 3; i++) step(1, mk(32'h1c00_0200 + 32'(4 * i)), 0, 0, 0);
    step(1, mk(32'h1c00_020c), 1, 0, 1);
    step(0, '0, 1, 0, 0);
    check("after_br_count", {125'd0, count}, 128'd0);

    // flush and br_taken together while full.
    for (int i = 0; i < 4; i++) step(1, mk(32'h1c00_0300 + 32'(4 * i)), 0, 0, 0);
    step(1, mk(32'h1c00_0310), 1, 1, 1);
    step(0, '0, 0, 0, 0);

    // Exception-carrying fake NOP passes through untouched.
    step(1, pack_bundle(32'h0280_0000, 32'h1c00_0400, 16'h8041), 0, 0, 0);
    check("ex_zip", out_zip, 128'h0280_0000_1c00_0400_8041);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);

    // Asynchronous reset mid-cycle with two entries buffered.
    step(1, mk(32'h1c00_0500), 0, 0, 0);
    step(1, mk(32'h1c00_0504), 0, 0, 0);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_rst_count", {125'd0, count}, 128'd0);
    check("async_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("async_rst_allowin", {127'd0, in_allowin}, 128'd1);
    exp_q.delete();
    #1 reset = 1'b0;
    @(posedge clk); #1;
    step(1, mk(32'h1c00_0600), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and the decode stage. It accepts packed fetch bundles (`{inst, pc, ex_fields}`) from fetch, buffers up to `DEPTH` of them, and presents them in order to decode. Its purpose is to decouple fetch from decode backpressure. It discards every buffered bundle when a pipeline redirect occurs (exception/ertn flush or taken branch).

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `WIDTH`, `` `IF2ID_LEN ``: bundle width (32 inst + 32 pc + `` `EX_FIELDS_LEN `` exception fields).

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears pointers, count and output state immediately.
- `flush` input 1: global redirect from WB.
- `br_taken` input 1: taken-branch redirect from decode.
- `in_valid` input 1: fetch presents a bundle.
- `in_zip` input `WIDTH`: fetch bundle.
- `in_allowin` output 1: queue can accept a bundle this cycle. Drives fetch's `id_allowin`.
- `out_valid` output 1: head bundle valid for decode.
- `out_zip` output `WIDTH`: head bundle.
- `out_ready` input 1: decode consumes head this cycle (decode's `id_allowin && !br_stall`).
- `count` output `$clog2(DEPTH+1)`: current occupancy.

## Operation
- Circular buffer with `rd_ptr` and `wr_ptr` (each `$clog2(DEPTH)` bits, natural wrap) and `count`.
- `clear = flush | br_taken`.
- `push = in_valid & in_allowin & !clear`.
- `pop = out_valid & out_ready`.
- `in_allowin = (count != DEPTH)`.
  - Registered-state only; no combinational path from `out_ready`.
  - A full queue refuses input even when a pop happens in the same cycle.
- `out_valid = (count != 0) & !clear`.
- `out_zip = mem[rd_ptr]`: first-word fall-through from storage. There is no input-to-output bypass.
- `clear` has priority over everything. On the next edge: `rd_ptr = wr_ptr = 0`, `count = 0`; any push or pop in that cycle is ignored. Storage contents are don't-care.
- Without `clear`, the update depends on the push/pop combination:
  - push only: write `mem[wr_ptr]`, `wr_ptr+1`, `count+1`.
  - pop only: `rd_ptr+1`, `count-1`.
  - both: both pointers advance, `count` unchanged.
- Exception-carrying bundles (fake NOP plus `ex_valid`) are ordinary entries; the queue never inspects their content.
- Fetch relies on the acceptance contract: a bundle is taken exactly when `in_valid & in_allowin` in a cycle without `clear`. Fetch already gates `in_valid` with `!flush & !br_taken`, and the queue gates `push` again for safety.

## Timing
- Reset values: `in_allowin = 1`, `out_valid = 0`, `count = 0`. `out_zip` is don't-care while `out_valid = 0`.
- Latency: a bundle pushed at edge N is visible with `out_valid = 1` in cycle N+1. Minimum pass-through is 1 cycle.
- Sustained throughput is 1 bundle/cycle when `DEPTH ≥ 2` and decode is always ready.
- Full (`count == DEPTH`): `in_allowin = 0` for the whole cycle. It deasserts combinationally from `count`, so fetch sees it in the same cycle.
- Empty: `out_valid = 0`, and a push in the same cycle does not produce output that cycle.
- Pointer wrap: `DEPTH-1 → 0` with no bubble.
- Clear while full or empty: next cycle `count = 0` and `in_allowin = 1`. `out_valid` is 0 during the clear cycle itself.
- `flush` and `br_taken` together: identical to either alone.
- Reset asserted mid-operation: state clears asynchronously; the first push is accepted on the first edge after deassertion.

## Structure
- `` `IF2ID_LEN `` and `` `EX_FIELDS_LEN `` come from the shared `macros.h`. No new global constants.
- Storage is a flop array of `DEPTH × WIDTH`; no SRAM macro.
- One natural sub-module, `fifo_ptr_ctrl`: pointer, count and full/empty logic, parameterised on `DEPTH`. The data array stays in `if_id_queue`.

## Test plan
- Reset, then push pc `0x1c000000`, `0x1c000004`, `0x1c000008` with `out_ready = 0` → `count = 3`, `in_allowin = 1`, head pc `0x1c000000`.
- Push 4 bundles with `out_ready = 0` → `count = 4`, `in_allowin = 0`. A 5th `in_valid` is not accepted. Set `out_ready = 1` for 4 cycles → pcs emerge in order and `count` returns to 0.
- Continuous push and pop for 10 cycles → one bundle out per cycle, `count` steady at 1, correct order across pointer wrap.
- `count = 3`, assert `br_taken` for one cycle with `in_valid = 1` → `out_valid = 0` that cycle, `count = 0` next cycle, the input bundle is dropped.
- Bundle with `ex_valid = 1` and inst `0x02800000` → emerges bit-identical at `out_zip`.
- Assert `reset` asynchronously mid-cycle at `count = 2` → `count = 0`, `out_valid = 0` before the next edge.
